// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// Three byte requesters share one TX pin; a requester is accepted only while the line is idle.
module uart_tx_arbiter #(
   parameter int CLKS_PER_BIT = 104,
   parameter int NUM_REQ      = 3
) (
   input  logic                   clk_12p0,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   tx,
   output logic                   busy,
   output logic [1:0]             grant_id
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  ptr_q, ptr_d;

   logic        win_vld;
   logic [1:0]  win_idx;
   logic        baud_tick;

   assign baud_tick = (baud_q == BAUD_LAST);

   // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic [2:0] sum;
      win_vld = 1'b0;
      win_idx = '0;
      sum     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + 3'(k);
         if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
         if (!win_vld && req_valid[sum[1:0]]) begin
            win_vld = 1'b1;
            win_idx = sum[1:0];
         end
      end
   end

   always_ff @(posedge clk_12p0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // tx_d is the value the line takes in the next cycle, so the pin is a plain flop output.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            tx_d   = 1'b1;
            if (win_vld) begin
               state_d = S_START;
               shift_d = req_data[{win_idx, 3'b000} +: 8];
               grant_d = win_idx;
               ptr_d   = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            if (baud_tick) begin
               baud_d  = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  bit_d   = '0;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_tick) begin
               baud_d  = '0;
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
      endcase
   end

   // Accept strobe is qualified with rst_n so it drops the moment reset asserts.
   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == S_IDLE && win_vld) req_ready[win_idx] = 1'b1;
   end

   assign tx       = tx_q;
   assign busy     = (state_q != S_IDLE);
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: a per-cycle frame model (bit slots of a 10-bit frame)
// plus directed scenarios; a second instance runs at the default bit time.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic        clk, rst_n;
   logic [2:0]  req_valid, req_ready;
   logic [23:0] req_data;
   logic        tx, busy;
   logic [1:0]  grant_id;

   logic [2:0]  v2, r2;
   logic [23:0] d2;
   logic        tx2, busy2;
   logic [1:0]  g2;

   uart_tx_arbiter #(.CLKS_PER_BIT(N)) u_dut (
      .clk_12p0(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id));

   uart_tx_arbiter u_dut104 (
      .clk_12p0(clk), .rst_n(rst_n), .req_valid(v2), .req_data(d2),
      .req_ready(r2), .tx(tx2), .busy(busy2), .grant_id(g2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: frame bits and cycles remaining in the current frame.
   logic [9:0] m_frame;
   int         m_cnt = 0, m_ptr = 0, m_grant = 0, last_acc = -1, n_acc = 0;
   int         gid_q[$];
   int         busy_cnt = 0, rdy_cnt = 0, txlo_cnt = 0;
   logic [2:0] drop_mask = '0;
   logic       s_tx2, s_busy2;
   logic [2:0] s_rdy2;

   function automatic int rr_pick(input logic [2:0] v, input int p);
      for (int k = 0; k < 3; k++)
         if (v[(p + k) % 3]) return (p + k) % 3;
      return -1;
   endfunction

   task automatic model_cycle();
      int         w, slot;
      logic [2:0] e;
      last_acc = -1;
      busy_cnt += int'(busy);
      rdy_cnt  += int'(req_ready != 3'b000);
      txlo_cnt += int'(!tx);
      if (!rst_n) begin
         m_cnt = 0; m_ptr = 0; m_grant = 0;
         chk("rst_tx", tx, 1); chk("rst_busy", busy, 0);
         chk("rst_ready", req_ready, 0); chk("rst_gid", grant_id, 0);
         return;
      end
      if (m_cnt == 0) begin
         w = rr_pick(req_valid, m_ptr);
         e = '0;
         if (w >= 0) e[w] = 1'b1;
         chk("idle_tx", tx, 1); chk("idle_busy", busy, 0);
         chk("ready", req_ready, e); chk("idle_gid", grant_id, m_grant);
         if (w >= 0) begin
            m_frame  = {1'b1, req_data[8*w +: 8], 1'b0};
            m_cnt    = 10 * N;
            m_grant  = w;
            m_ptr    = (w + 1) % 3;
            last_acc = w;
            n_acc++;
         end
      end else begin
         slot = (10 * N - m_cnt) / N;
         chk("frame_tx", tx, m_frame[slot]); chk("frame_busy", busy, 1);
         chk("frame_ready", req_ready, 0); chk("frame_gid", grant_id, m_grant);
         if (m_cnt == 10 * N) gid_q.push_back(int'(grant_id));
         m_cnt--;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle();
      s_tx2 = tx2; s_rdy2 = r2; s_busy2 = busy2;
      @(posedge clk);
      #1;
      if (last_acc >= 0 && drop_mask[last_acc]) req_valid[last_acc] = 1'b0;
   endtask

   task automatic wait_acc(input int target, input int limit, input string tag);
      int k = 0;
      while (n_acc < target && k < limit) begin tick(); k++; end
      chk(tag, n_acc >= target, 1);
   endtask

   task automatic drain(input int limit, input string tag);
      int k = 0;
      while (m_cnt != 0 && k < limit) begin tick(); k++; end
      chk(tag, m_cnt == 0, 1);
   endtask

   initial begin
      int s, lo, hi;
      int exp_gid[6] = '{0, 1, 2, 0, 2, 0};
      rst_n = 1'b0; req_valid = '0; req_data = '0; v2 = '0; d2 = '0;
      repeat (3) tick();
      chk("reset_tx", tx, 1); chk("reset_busy", busy, 0);
      chk("reset_gid", grant_id, 0); chk("reset_ready", req_ready, 0);
      rst_n = 1'b1;

      // Default bit time, byte 0x00: start + 8 zero bits low, then stop high.
      v2 = 3'b001; d2 = '0;
      tick();
      chk("r033_ready", s_rdy2, 3'b001);
      v2 = '0;
      tick();
      chk("r033_first_low", s_tx2, 0);
      chk("r033_busy", s_busy2, 1);
      lo = 1;
      for (int k = 0; k < 1100; k++) begin
         tick();
         if (s_tx2 == 1'b0) lo++;
         else break;
      end
      chk("r033_low_cycles", lo, 936);
      hi = 1;
      repeat (103) begin tick(); hi += int'(s_tx2); end
      chk("r033_high_cycles", hi, 104);

      // Three contenders, then only 0 and 2 stay valid.
      gid_q.delete();
      req_data = {8'hC3, 8'hB2, 8'hA1}; req_valid = 3'b111; drop_mask = 3'b010;
      s = n_acc;
      wait_acc(s + 6, 600, "r029_timeout");
      req_valid = '0;
      drain(100, "r029_drain");
      chk("r029_count", gid_q.size(), 6);
      for (int i = 0; i < 6 && i < gid_q.size(); i++) chk($sformatf("r029_gid%0d", i), gid_q[i], exp_gid[i]);

      // Single 0x55 frame from requester 0.
      drop_mask = 3'b111; busy_cnt = 0; rdy_cnt = 0;
      req_data[7:0] = 8'h55; req_valid = 3'b001;
      s = n_acc;
      wait_acc(s + 1, 20, "r028_timeout");
      drain(100, "r028_drain");
      chk("r028_busy_cycles", busy_cnt, 40);
      chk("r028_ready_cycles", rdy_cnt, 1);
      chk("r028_gid", gid_q[$], 0);

      // Reset in the middle of data bit 3.
      req_data[23:16] = 8'($urandom) | 8'h08; req_valid = 3'b100;
      s = n_acc;
      wait_acc(s + 1, 20, "r031_timeout");
      for (int k = 0; k < 100 && m_cnt > 10 * N - 4 * N - 2; k++) tick();
      chk("r031_pre_tx", tx, 1);
      req_valid = 3'b111;
      rst_n = 1'b0;
      #1;
      chk("r031_async_tx", tx, 1); chk("r031_async_busy", busy, 0);
      chk("r031_async_ready", req_ready, 0); chk("r031_async_gid", grant_id, 0);
      tick(); tick();
      req_data[15:8] = 8'h0F; req_valid = 3'b010;
      rst_n = 1'b1;
      tick();
      chk("r031_first_edge_acc", last_acc, 1);
      drain(100, "r031_drain");
      chk("r031_gid", gid_q[$], 1);

      // Long idle stretch.
      busy_cnt = 0; rdy_cnt = 0; txlo_cnt = 0; req_valid = '0;
      repeat (1000) tick();
      chk("r032_busy", busy_cnt, 0); chk("r032_ready", rdy_cnt, 0); chk("r032_txlow", txlo_cnt, 0);

      // Random traffic: requests appear, withdraw, and get refreshed mid-frame.
      drop_mask = '0;
      s = n_acc;
      repeat (4000) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (last_acc == i) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_data[8*i +: 8] = 8'($urandom);
            end else if (!req_valid[i]) begin
               req_data[8*i +: 8] = 8'($urandom);
               if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b1;
            end else if ($urandom_range(0, 63) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      drain(100, "rand_drain");
      chk("rand_accepts", n_acc > s + 20, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
